video_timing_controller: RTL and testbench

Generates the raster scan that sequences the colour-bar/pixel datapath. It produces the `video_x`/`video_y` coordinates, active-area flag, sync pulses and a frame-start strobe. It also hands the datapath a frame-stable copy of the mouse state. It sits between the pixel clock domain's top level and the pixel generator, and is the only source of scan position in the design.

---
 rtl/video_timing_controller.sv | 174 +++++++++++++++++
 tb/tb_video_timing_controller.sv | 138 +++++++++++++
 2 files changed

// File: rtl/video_timing_controller.sv
// Raster scan generator: position, active area, syncs, frame strobe and frame-stable mouse.
// Define VIDEO_TIMING_MOUSE_LATCH_EN to latch the mouse inputs at each frame start.
module video_timing_controller #(
    parameter int H_ACTIVE = 352,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 32,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 288,
    parameter int V_FRONT  = 4,
    parameter int V_SYNC   = 4,
    parameter int V_BACK   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pixel_enable,
    input  logic [8:0] mouse_x_in,
    input  logic [8:0] mouse_y_in,
    input  logic       mouse_pressed_in,
    output logic [8:0] video_x,
    output logic [8:0] video_y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic [8:0] mouse_x,
    output logic [8:0] mouse_y,
    output logic       mouse_pressed_
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        H_TOTAL > 512 || V_TOTAL > 512) begin : g_param_check
        $fatal(1, "video_timing_controller: illegal timing parameters");
    end

    typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
    typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;

    h_state_t   h_state_reg, h_state_next;
    v_state_t   v_state_reg, v_state_next;
    logic [8:0] h_phase_reg, h_phase_next, v_phase_reg, v_phase_next;
    logic [8:0] x_reg, x_next, y_reg, y_next;
    logic [8:0] h_last, v_last;
    logic       line_wrap, frame_wrap;
    logic       active_reg, active_next, hsync_reg, hsync_next;
    logic       vsync_reg, vsync_next, frame_start_reg, frame_start_next;

    // State register: reset parks both FSMs on the last count of the back porch,
    // so the first enabled cycle wraps into (0,0) like any other frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_state_reg     <= HS_BP;
            v_state_reg     <= VS_BP;
            h_phase_reg     <= 9'(H_BACK - 1);
            v_phase_reg     <= 9'(V_BACK - 1);
            x_reg           <= 9'(H_TOTAL - 1);
            y_reg           <= 9'(V_TOTAL - 1);
            active_reg      <= 1'b0;
            hsync_reg       <= 1'b0;
            vsync_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            h_state_reg     <= h_state_next;
            v_state_reg     <= v_state_next;
            h_phase_reg     <= h_phase_next;
            v_phase_reg     <= v_phase_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            active_reg      <= active_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            frame_start_reg <= frame_start_next;
        end
    end

    // Next-state logic for both scan FSMs and the position counters.
    always_comb begin
        h_last = 9'(H_BACK - 1);
        case (h_state_reg)
            HS_ACT:  h_last = 9'(H_ACTIVE - 1);
            HS_FP:   h_last = 9'(H_FRONT - 1);
            HS_SYNC: h_last = 9'(H_SYNC - 1);
            default: h_last = 9'(H_BACK - 1);
        endcase
        v_last = 9'(V_BACK - 1);
        case (v_state_reg)
            VS_ACT:  v_last = 9'(V_ACTIVE - 1);
            VS_FP:   v_last = 9'(V_FRONT - 1);
            VS_SYNC: v_last = 9'(V_SYNC - 1);
            default: v_last = 9'(V_BACK - 1);
        endcase

        line_wrap    = pixel_enable && (x_reg == 9'(H_TOTAL - 1));
        frame_wrap   = line_wrap && (y_reg == 9'(V_TOTAL - 1));
        h_state_next = h_state_reg;
        h_phase_next = h_phase_reg;
        v_state_next = v_state_reg;
        v_phase_next = v_phase_reg;
        x_next       = x_reg;
        y_next       = y_reg;

        if (pixel_enable) begin
            x_next = line_wrap ? 9'd0 : x_reg + 9'd1;
            if (h_phase_reg == h_last) begin
                h_phase_next = 9'd0;
                case (h_state_reg)
                    HS_ACT:  h_state_next = HS_FP;
                    HS_FP:   h_state_next = HS_SYNC;
                    HS_SYNC: h_state_next = HS_BP;
                    default: h_state_next = HS_ACT;
                endcase
            end else begin
                h_phase_next = h_phase_reg + 9'd1;
            end
        end

        if (line_wrap) begin
            y_next = frame_wrap ? 9'd0 : y_reg + 9'd1;
            if (v_phase_reg == v_last) begin
                v_phase_next = 9'd0;
                case (v_state_reg)
                    VS_ACT:  v_state_next = VS_FP;
                    VS_FP:   v_state_next = VS_SYNC;
                    VS_SYNC: v_state_next = VS_BP;
                    default: v_state_next = VS_ACT;
                endcase
            end else begin
                v_phase_next = v_phase_reg + 9'd1;
            end
        end
    end

    // Output decode from the next state, registered alongside the state.
    always_comb begin
        active_next      = (h_state_next == HS_ACT) && (v_state_next == VS_ACT);
        hsync_next       = (h_state_next == HS_SYNC);
        vsync_next       = (v_state_next == VS_SYNC);
        frame_start_next = frame_wrap;
    end

    assign video_x     = x_reg;
    assign video_y     = y_reg;
    assign active      = active_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign frame_start = frame_start_reg;

`ifdef VIDEO_TIMING_MOUSE_LATCH_EN
    logic [8:0] mouse_x_reg, mouse_y_reg;
    logic       mouse_pressed_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            mouse_x_reg       <= 9'd0;
            mouse_y_reg       <= 9'd0;
            mouse_pressed_reg <= 1'b0;
        end else if (frame_wrap) begin
            mouse_x_reg       <= mouse_x_in;
            mouse_y_reg       <= mouse_y_in;
            mouse_pressed_reg <= mouse_pressed_in;
        end
    end

    assign mouse_x        = mouse_x_reg;
    assign mouse_y        = mouse_y_reg;
    assign mouse_pressed_ = mouse_pressed_reg;
`else
    assign mouse_x        = mouse_x_in;
    assign mouse_y        = mouse_y_in;
    assign mouse_pressed_ = mouse_pressed_in;
`endif
endmodule

// File: tb/tb_video_timing_controller.sv
// Randomized bench for video_timing_controller against a position-based raster model.
// Uses a reduced raster (32 x 17) so several full frames fit in a short run.
module tb_video_timing_controller;
    localparam int HA = 20, HF = 3, HS = 4, HB = 5;
    localparam int VA = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       clock = 1'b0;
    logic       reset, pixel_enable;
    logic [8:0] mouse_x_in, mouse_y_in;
    logic       mouse_pressed_in;
    logic [8:0] video_x, video_y, mouse_x, mouse_y;
    logic       active, hsync, vsync, frame_start, mouse_pressed_;

    video_timing_controller #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clock(clock), .reset(reset), .pixel_enable(pixel_enable),
        .mouse_x_in(mouse_x_in), .mouse_y_in(mouse_y_in),
        .mouse_pressed_in(mouse_pressed_in),
        .video_x(video_x), .video_y(video_y), .active(active),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_pressed_(mouse_pressed_)
    );

    always #5 clock = ~clock;

    int n_pass = 0, n_total = 0;
    int mx, my;
    bit fs_m;
    bit rand_mouse = 1'b1;
    logic [8:0] lx, ly;
    logic lp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (model pos %0d,%0d)", tag, obs, exp, mx, my);
    endtask

    task automatic check_all();
        chk("video_x", 32'(video_x), 32'(mx));
        chk("video_y", 32'(video_y), 32'(my));
        chk("active", 32'(active), 32'(mx < HA && my < VA));
        chk("hsync", 32'(hsync), 32'(mx >= HA + HF && mx < HA + HF + HS));
        chk("vsync", 32'(vsync), 32'(my >= VA + VF && my < VA + VF + VS));
        chk("frame_start", 32'(frame_start), 32'(fs_m));
`ifdef VIDEO_TIMING_MOUSE_LATCH_EN
        chk("mouse_x", 32'(mouse_x), 32'(lx));
        chk("mouse_y", 32'(mouse_y), 32'(ly));
        chk("mouse_pressed", 32'(mouse_pressed_), 32'(lp));
`else
        chk("mouse_x", 32'(mouse_x), 32'(mouse_x_in));
        chk("mouse_y", 32'(mouse_y), 32'(mouse_y_in));
        chk("mouse_pressed", 32'(mouse_pressed_), 32'(mouse_pressed_in));
`endif
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1 time unit later.
    task automatic step(input logic rst, input logic en);
        reset = rst;
        pixel_enable = en;
        if (rand_mouse && $urandom_range(0, 7) == 0) begin
            mouse_x_in = 9'($urandom);
            mouse_y_in = 9'($urandom);
            mouse_pressed_in = 1'($urandom);
        end
        @(posedge clock);
        if (rst) begin
            mx = HT - 1; my = VT - 1; fs_m = 1'b0;
            lx = 9'd0; ly = 9'd0; lp = 1'b0;
        end else if (en) begin
            mx++;
            if (mx == HT) begin
                mx = 0;
                my++;
                if (my == VT) my = 0;
            end
            fs_m = (mx == 0 && my == 0);
            if (fs_m) begin
                lx = mouse_x_in; ly = mouse_y_in; lp = mouse_pressed_in;
            end
        end else begin
            fs_m = 1'b0;
        end
        #1;
        check_all();
    endtask

    task automatic run_to(input int tx, input int ty, input int budget);
        int k = 0;
        while (!(mx == tx && my == ty) && k < budget) begin
            step(1'b0, 1'b1);
            k++;
        end
        chk("run_to_x", 32'(video_x), 32'(tx));
        chk("run_to_y", 32'(video_y), 32'(ty));
    endtask

    initial begin
        mx = HT - 1; my = VT - 1; fs_m = 1'b0;
        lx = 9'd0; ly = 9'd0; lp = 1'b0;
        mouse_x_in = 9'd5; mouse_y_in = 9'd6; mouse_pressed_in = 1'b1;

        // Reset with pixel_enable high, then first frame start and its strobe drop.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // 1-in-3 enable pattern, then random enables over several frames.
        for (int i = 0; i < 150; i++) step(1'b0, (i % 3) == 0);
        for (int i = 0; i < 1400; i++) step(1'b0, $urandom_range(0, 3) != 0);

        // Mouse held at 10 across a frame start, changed to 77 mid-frame.
        rand_mouse = 1'b0;
        mouse_x_in = 9'd10;
        run_to(0, 0, 2 * HT * VT);
        run_to(HA / 2, VA / 2, 2 * HT * VT);
        mouse_x_in = 9'd77;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        run_to(0, 0, 2 * HT * VT);
        step(1'b0, 1'b1);
        rand_mouse = 1'b1;

        // Reset mid-frame overrides an enabled cycle, then the scan restarts at (0,0).
        run_to(HA / 2, VA / 2, 2 * HT * VT);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 700; i++) step(1'b0, $urandom_range(0, 2) != 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
